vau_cmd_frontend: RTL and testbench
===================================

// Module: vau_cmd_frontend
// PURPOSE
//  Wishbone slave in user_project_wrapper; the upstream stage feeding the vector accelerator unit (VAU).
//  Firmware writes 32-bit vector instructions into a FIFO, and the block issues them to the VAU over valid/ready.
//  While the VAU has work, the block drives a busy flag on mprj_io[20] and counts busy cycles in a perf counter.
// PARAMETERS
//  BASE_ADDR   32'h3000_0000  Wishbone base address; decode is on wbs_adr_i[31:4], and [3:2] selects the register
//  FIFO_DEPTH  8              Instruction FIFO entries; must be a power of 2, >=2
//  MAX_OUTS    4              Max instructions issued to VAU without a matching vau_done (1..15)
// PORTS
//  clock        in   1   system clock (wb_clk_i)
//  resetb       in   1   asynchronous, active-low reset
//  wbs_cyc_i    in   1   Wishbone cycle
//  wbs_stb_i    in   1   Wishbone strobe
//  wbs_we_i     in   1   Wishbone write enable
//  wbs_sel_i    in   4   byte selects; a write commits only when all 4 are set
//  wbs_adr_i    in   32  byte address
//  wbs_dat_i    in   32  write data
//  wbs_ack_o    out  1   Wishbone acknowledge
//  wbs_dat_o    out  32  read data
//  inst_valid   out  1   instruction available to VAU
//  inst_data    out  32  instruction word (FIFO head)
//  inst_ready   in   1   VAU accepts the instruction on valid&ready
//  vau_done     in   1   one-cycle pulse per completed instruction
//  busy_flag    out  1   drives io_out[20]; io_oeb[20] is tied 0 in the wrapper
// BEHAVIOUR
//  Reset: all outputs are 0; FIFO is empty; outs_cnt=0; cycles=0; ovf=0; flag_en=1.
//  WB:
//   - sel = cyc & stb & adr hit.
//   - ack <= sel & ~ack, so ack is a 1-cycle pulse 1 clock after the request; no wait states.
//   - wbs_dat_o is valid with ack and is 0 otherwise.
//  Registers (word offsets):
//   0x0 CMD   W  push wbs_dat_i into the FIFO; reads 0
//   0x4 STAT  R  {22'b0, ovf, outs_cnt[3:0], busy, full, empty, 2'b0}; count is not exposed
//   0x8 CYC   R  32-bit busy-cycle counter
//   0xC CTRL  W  bit0=1 clears cycles and ovf (self-clearing); bit1=flag_en; reads {30'b0, flag_en, 1'b0}
//  Writes commit on the cycle ack is raised; reads are sampled the same cycle.
//  FIFO:
//   - push = CMD write commit; pop = inst_valid & inst_ready.
//   - Push while full with no pop in the same cycle: word dropped, ovf<=1 (sticky), ack still given.
//   - Push while full with a pop in the same cycle: accepted.
//   - Pointers wrap modulo FIFO_DEPTH; count width is clog2(FIFO_DEPTH)+1.
//  Issue:
//   - inst_valid = ~empty & (outs_cnt < MAX_OUTS); combinational from registered state.
//   - inst_data = mem[rd_ptr], held stable while valid & ~ready.
//   - outs_cnt += pop, -= vau_done; pop and done in the same cycle leaves it unchanged.
//   - vau_done with outs_cnt==0 is ignored; no underflow.
//  Busy:
//   - busy_i = ~empty | (outs_cnt != 0).
//   - busy_flag <= busy_i & flag_en, registered, so it trails busy_i by 1 cycle.
//  Cycles:
//   - Increments on each clock where busy_flag==1 and saturates at 32'hFFFF_FFFF.
//   - A clear has priority over an increment in the same cycle.
//  resetb low mid-operation: all state clears immediately; in-flight VAU work is not tracked afterwards.
// STRUCTURE
//  vau_pkg: register offsets (CMD/STAT/CYC/CTRL), STAT bit positions, CTRL bit positions.
//  Sub-module vau_sync_fifo (WIDTH, DEPTH): push/pop/full/empty/count; everything else stays in this module.
// TESTING
//  1. Reset: hold resetb=0 for 10 cycles -> ack=0, inst_valid=0, busy_flag=0; STAT read = 32'h0000_0004.
//  2. Single issue:
//     - Write CMD=32'hDEAD_BEEF with inst_ready=1 -> inst_valid for 1 cycle with data DEADBEEF.
//     - busy_flag=1 until vau_done, then 0.
//     - CYC equals the number of cycles busy_flag was high.
//  3. Backpressure and limit: inst_ready=0, push 6 words -> valid held, data stable.
//     - Raise ready -> exactly 4 (MAX_OUTS) pops, then valid=0.
//     - Each vau_done releases 1 more pop; order is preserved.
//  4. Overflow: inst_ready=0, push 9 words with FIFO_DEPTH=8 -> STAT.full=1, STAT.ovf=1.
//     - Word 9 is lost.
//     - CTRL=32'h3 clears ovf while FIFO contents are retained.
//  5. Simultaneous events:
//     - Push while full in the same cycle as a pop -> accepted, full stays 1.
//     - Pop and vau_done in the same cycle -> outs_cnt unchanged.
//     - vau_done at outs_cnt=0 -> no change.
//  6. Async reset while 3 entries are queued and 2 outstanding -> all state is 0 within the reset assertion.
//     - busy_flag drops without waiting for a clock edge.

Source files
------------

// File: rtl/vau_pkg.sv
// Register map and bit positions shared by the VAU command front end.
// Latency: n/a (constants only).
// Backpressure: n/a.
package vau_pkg;

    localparam logic [1:0] REG_CMD  = 2'd0;
    localparam logic [1:0] REG_STAT = 2'd1;
    localparam logic [1:0] REG_CYC  = 2'd2;
    localparam logic [1:0] REG_CTRL = 2'd3;

    localparam int STAT_EMPTY    = 2;
    localparam int STAT_FULL     = 3;
    localparam int STAT_BUSY     = 4;
    localparam int STAT_OUTS_LSB = 5;
    localparam int STAT_OVF      = 9;

    localparam int CTRL_CLR     = 0;
    localparam int CTRL_FLAG_EN = 1;

endpackage

// File: rtl/vau_sync_fifo.sv
// Single-clock FIFO with power-of-2 depth; head word visible combinationally.
// Latency: a pushed word is at the head 1 cycle after the push when empty.
// Backpressure: caller must not push when full without a same-cycle pop, nor pop when empty.
module vau_sync_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 8
) (
    input  logic                     clock,
    input  logic                     resetb,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_dat,
    input  logic                     pop,
    output logic [WIDTH-1:0]         head_dat,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;

    always_ff @(posedge clock or negedge resetb) begin
        if (!resetb) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            count <= count + CW'(push) - CW'(pop);
        end
    end

    // A push into a full FIFO with a concurrent pop overwrites the slot being read out.
    always_ff @(posedge clock) begin
        if (push) mem[wr_ptr] <= push_dat;
    end

    assign head_dat = mem[rd_ptr];
    assign full     = (count == CW'(DEPTH));
    assign empty    = (count == '0);

endmodule

// File: rtl/vau_cmd_frontend.sv
// Wishbone slave queueing VAU instructions and issuing them over valid/ready with an outstanding limit.
// Latency: ack 1 cycle after request; a pushed word is offered to the VAU the cycle after commit.
// Backpressure: inst_valid holds while ~inst_ready or outstanding==MAX_OUTS; writes to a full FIFO drop and set ovf.
module vau_cmd_frontend
    import vau_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR  = 32'h3000_0000,
    parameter int          FIFO_DEPTH = 8,
    parameter int          MAX_OUTS   = 4
) (
    input  logic        clock,
    input  logic        resetb,
    input  logic        wbs_cyc_i,
    input  logic        wbs_stb_i,
    input  logic        wbs_we_i,
    input  logic [3:0]  wbs_sel_i,
    input  logic [31:0] wbs_adr_i,
    input  logic [31:0] wbs_dat_i,
    output logic        wbs_ack_o,
    output logic [31:0] wbs_dat_o,
    output logic        inst_valid,
    output logic [31:0] inst_data,
    input  logic        inst_ready,
    input  logic        vau_done,
    output logic        busy_flag
);
    localparam logic [3:0] MAX_OUTS_C = 4'(MAX_OUTS);

    logic        wb_sel, wb_req, wr_commit, cmd_wr, ctrl_wr, cyc_clr;
    logic [1:0]  reg_idx;
    logic        pop, fifo_push, drop, done_eff, busy_i;
    logic        fifo_full, fifo_empty;
    logic [$clog2(FIFO_DEPTH):0] fifo_count;
    logic [3:0]  outs_cnt;
    logic        ovf, flag_en;
    logic [31:0] cycles;
    logic [31:0] rd_mux;
    logic        unused_bits;

    assign wb_sel    = wbs_cyc_i & wbs_stb_i & (wbs_adr_i[31:4] == BASE_ADDR[31:4]);
    assign wb_req    = wb_sel & ~wbs_ack_o;
    assign reg_idx   = wbs_adr_i[3:2];
    assign wr_commit = wb_req & wbs_we_i & (&wbs_sel_i);
    assign cmd_wr    = wr_commit & (reg_idx == REG_CMD);
    assign ctrl_wr   = wr_commit & (reg_idx == REG_CTRL);
    assign cyc_clr   = ctrl_wr & wbs_dat_i[CTRL_CLR];

    assign pop       = inst_valid & inst_ready;
    assign fifo_push = cmd_wr & (~fifo_full | pop);
    assign drop      = cmd_wr & fifo_full & ~pop;
    assign done_eff  = vau_done & (outs_cnt != 4'd0);

    assign inst_valid = ~fifo_empty & (outs_cnt < MAX_OUTS_C);
    assign busy_i     = ~fifo_empty | (outs_cnt != 4'd0);

    // Byte lanes and FIFO occupancy are not part of the register map.
    assign unused_bits = ^{wbs_adr_i[1:0], fifo_count};

    vau_sync_fifo #(
        .WIDTH (32),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clock    (clock),
        .resetb   (resetb),
        .push     (fifo_push),
        .push_dat (wbs_dat_i),
        .pop      (pop),
        .head_dat (inst_data),
        .full     (fifo_full),
        .empty    (fifo_empty),
        .count    (fifo_count)
    );

    always_comb begin
        rd_mux = '0;
        case (reg_idx)
            REG_STAT: begin
                rd_mux[STAT_EMPTY]          = fifo_empty;
                rd_mux[STAT_FULL]           = fifo_full;
                rd_mux[STAT_BUSY]           = busy_i;
                rd_mux[STAT_OUTS_LSB +: 4]  = outs_cnt;
                rd_mux[STAT_OVF]            = ovf;
            end
            REG_CYC:  rd_mux = cycles;
            REG_CTRL: rd_mux[CTRL_FLAG_EN] = flag_en;
            default:  rd_mux = '0;
        endcase
    end

    always_ff @(posedge clock or negedge resetb) begin
        if (!resetb) begin
            wbs_ack_o <= 1'b0;
            wbs_dat_o <= '0;
            outs_cnt  <= '0;
            ovf       <= 1'b0;
            flag_en   <= 1'b1;
            busy_flag <= 1'b0;
            cycles    <= '0;
        end else begin
            wbs_ack_o <= wb_req;
            wbs_dat_o <= (wb_req & ~wbs_we_i) ? rd_mux : '0;
            outs_cnt  <= outs_cnt + {3'b0, pop} - {3'b0, done_eff};
            if (cyc_clr)   ovf <= 1'b0;
            else if (drop) ovf <= 1'b1;
            if (ctrl_wr) flag_en <= wbs_dat_i[CTRL_FLAG_EN];
            busy_flag <= busy_i & flag_en;
            // Clear wins over increment; the counter sticks at all-ones.
            if (cyc_clr)                           cycles <= '0;
            else if (busy_flag && cycles != '1)    cycles <= cycles + 1'b1;
        end
    end

endmodule

// File: tb/tb_vau_cmd_frontend.sv
// Directed bench for vau_cmd_frontend: Wishbone register access, issue limit, overflow, async reset.
module tb_vau_cmd_frontend;

    localparam logic [31:0] BASE = 32'h3000_0000;
    localparam logic [31:0] OFF_CMD  = 32'h0;
    localparam logic [31:0] OFF_STAT = 32'h4;
    localparam logic [31:0] OFF_CYC  = 32'h8;
    localparam logic [31:0] OFF_CTRL = 32'hC;

    logic        clock = 1'b0;
    logic        resetb;
    logic        wbs_cyc_i, wbs_stb_i, wbs_we_i;
    logic [3:0]  wbs_sel_i;
    logic [31:0] wbs_adr_i, wbs_dat_i;
    logic        wbs_ack_o;
    logic [31:0] wbs_dat_o;
    logic        inst_valid;
    logic [31:0] inst_data;
    logic        inst_ready, vau_done;
    logic        busy_flag;

    int checks = 0;
    int errors = 0;
    logic [31:0] rd;
    logic [31:0] got[$];

    vau_cmd_frontend dut (
        .clock      (clock),
        .resetb     (resetb),
        .wbs_cyc_i  (wbs_cyc_i),
        .wbs_stb_i  (wbs_stb_i),
        .wbs_we_i   (wbs_we_i),
        .wbs_sel_i  (wbs_sel_i),
        .wbs_adr_i  (wbs_adr_i),
        .wbs_dat_i  (wbs_dat_i),
        .wbs_ack_o  (wbs_ack_o),
        .wbs_dat_o  (wbs_dat_o),
        .inst_valid (inst_valid),
        .inst_data  (inst_data),
        .inst_ready (inst_ready),
        .vau_done   (vau_done),
        .busy_flag  (busy_flag)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] got_v, input logic [31:0] exp_v);
        checks++;
        if (got_v !== exp_v) begin
            errors++;
            $display("FAIL %s: got %08h expected %08h", tag, got_v, exp_v);
        end
    endtask

    // Called at a negedge; returns at the negedge where ack is seen.
    task automatic wb_xfer(input logic we, input logic [3:0] sel, input logic [31:0] off,
                           input logic [31:0] wdat, output logic [31:0] rdat);
        bit acked = 0;
        if (wbs_ack_o) @(negedge clock);
        wbs_cyc_i = 1'b1;
        wbs_stb_i = 1'b1;
        wbs_we_i  = we;
        wbs_sel_i = sel;
        wbs_adr_i = BASE + off;
        wbs_dat_i = wdat;
        rdat      = '0;
        for (int i = 0; i < 4 && !acked; i++) begin
            @(negedge clock);
            if (wbs_ack_o) begin
                acked = 1;
                rdat  = wbs_dat_o;
            end
        end
        wbs_cyc_i = 1'b0;
        wbs_stb_i = 1'b0;
        wbs_we_i  = 1'b0;
        if (!acked) chk("wb_ack_timeout", {31'b0, wbs_ack_o}, 32'd1);
    endtask

    task automatic wb_write(input logic [31:0] off, input logic [31:0] wdat);
        logic [31:0] dummy;
        wb_xfer(1'b1, 4'hF, off, wdat, dummy);
    endtask

    task automatic wb_read(input logic [31:0] off, output logic [31:0] rdat);
        wb_xfer(1'b0, 4'hF, off, 32'h0, rdat);
    endtask

    initial begin
        resetb = 1'b0;
        wbs_cyc_i = 1'b0; wbs_stb_i = 1'b0; wbs_we_i = 1'b0;
        wbs_sel_i = 4'h0; wbs_adr_i = '0; wbs_dat_i = '0;
        inst_ready = 1'b0; vau_done = 1'b0;

        // 1. Reset
        repeat (10) @(negedge clock);
        chk("rst_ack", {31'b0, wbs_ack_o}, 32'd0);
        chk("rst_valid", {31'b0, inst_valid}, 32'd0);
        chk("rst_busy", {31'b0, busy_flag}, 32'd0);
        chk("rst_dat", wbs_dat_o, 32'd0);
        resetb = 1'b1;
        @(negedge clock);
        wb_read(OFF_STAT, rd); chk("rst_stat", rd, 32'h0000_0004);
        wb_read(OFF_CTRL, rd); chk("rst_ctrl", rd, 32'h0000_0002);
        wb_read(OFF_CYC, rd);  chk("rst_cyc", rd, 32'h0);
        @(negedge clock);
        chk("dat_idle", wbs_dat_o, 32'h0);
        wb_xfer(1'b1, 4'h7, OFF_CMD, 32'h1234_5678, rd);
        chk("partial_sel_no_push", {31'b0, inst_valid}, 32'd0);

        // 2. Single issue
        inst_ready = 1'b1;
        wb_write(OFF_CMD, 32'hDEAD_BEEF);
        chk("t2_valid", {31'b0, inst_valid}, 32'd1);
        chk("t2_data", inst_data, 32'hDEAD_BEEF);
        @(negedge clock);
        chk("t2_valid_gone", {31'b0, inst_valid}, 32'd0);
        chk("t2_busy_hi", {31'b0, busy_flag}, 32'd1);
        inst_ready = 1'b0;
        repeat (3) @(negedge clock);
        vau_done = 1'b1;
        @(negedge clock);
        vau_done = 1'b0;
        chk("t2_busy_trail", {31'b0, busy_flag}, 32'd1);
        @(negedge clock);
        chk("t2_busy_lo", {31'b0, busy_flag}, 32'd0);
        wb_read(OFF_CYC, rd); chk("t2_cyc", rd, 32'd5);

        // 3. Backpressure and outstanding limit
        for (int i = 0; i < 6; i++) wb_write(OFF_CMD, 32'hA000_0000 + i);
        chk("t3_valid_held", {31'b0, inst_valid}, 32'd1);
        chk("t3_data_w0", inst_data, 32'hA000_0000);
        @(negedge clock);
        chk("t3_data_stable", inst_data, 32'hA000_0000);
        got.delete();
        inst_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            if (inst_valid) got.push_back(inst_data);
            @(negedge clock);
        end
        chk("t3_pop_count", 32'(got.size()), 32'd4);
        for (int i = 0; i < 4; i++) chk("t3_order", got[i], 32'hA000_0000 + i);
        chk("t3_valid_limit", {31'b0, inst_valid}, 32'd0);
        for (int i = 4; i < 6; i++) begin
            vau_done = 1'b1;
            @(negedge clock);
            vau_done = 1'b0;
            chk("t3_release_valid", {31'b0, inst_valid}, 32'd1);
            chk("t3_release_data", inst_data, 32'hA000_0000 + i);
            @(negedge clock);
            chk("t3_relimit", {31'b0, inst_valid}, 32'd0);
        end
        vau_done = 1'b1;
        repeat (4) @(negedge clock);
        vau_done = 1'b0;
        inst_ready = 1'b0;
        wb_read(OFF_STAT, rd); chk("t3_stat_idle", rd, 32'h0000_0004);

        // 4. Overflow
        for (int i = 0; i < 9; i++) wb_write(OFF_CMD, 32'hB000_0000 + i);
        wb_read(OFF_STAT, rd); chk("t4_stat_ovf", rd, 32'h0000_0218);
        wb_write(OFF_CTRL, 32'h3);
        wb_read(OFF_CYC, rd);  chk("t4_cyc_cleared", rd, 32'd1);
        wb_read(OFF_STAT, rd); chk("t4_stat_clr", rd, 32'h0000_0018);

        // 5. Simultaneous events
        @(negedge clock);
        chk("t5_head_v0", inst_data, 32'hB000_0000);
        inst_ready = 1'b1;
        wb_write(OFF_CMD, 32'hC0DE_0009);
        inst_ready = 1'b0;
        wb_read(OFF_STAT, rd); chk("t5_push_pop_full", rd, 32'h0000_0038);
        @(negedge clock);
        chk("t5_head_v1", inst_data, 32'hB000_0001);
        inst_ready = 1'b1;
        vau_done = 1'b1;
        @(negedge clock);
        inst_ready = 1'b0;
        vau_done = 1'b0;
        wb_read(OFF_STAT, rd); chk("t5_pop_done", rd, 32'h0000_0030);
        vau_done = 1'b1;
        @(negedge clock);
        @(negedge clock);
        vau_done = 1'b0;
        wb_read(OFF_STAT, rd); chk("t5_done_at_zero", rd, 32'h0000_0010);
        got.delete();
        inst_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            if (inst_valid) got.push_back(inst_data);
            @(negedge clock);
        end
        inst_ready = 1'b0;
        chk("t5_pop_count", 32'(got.size()), 32'd4);
        for (int i = 0; i < 4; i++) chk("t5_order", got[i], 32'hB000_0002 + i);
        vau_done = 1'b1;
        repeat (2) @(negedge clock);
        vau_done = 1'b0;
        chk("t5_head_v6", inst_data, 32'hB000_0006);
        wb_read(OFF_STAT, rd); chk("t5_stat_q3_o2", rd, 32'h0000_0050);

        // 6. Asynchronous reset mid-operation
        @(negedge clock);
        chk("t6_busy_before", {31'b0, busy_flag}, 32'd1);
        #1 resetb = 1'b0;
        #1;
        chk("t6_busy_async", {31'b0, busy_flag}, 32'd0);
        chk("t6_valid_async", {31'b0, inst_valid}, 32'd0);
        chk("t6_dat_async", wbs_dat_o, 32'd0);
        repeat (3) @(negedge clock);
        resetb = 1'b1;
        wb_read(OFF_STAT, rd); chk("t6_stat", rd, 32'h0000_0004);
        wb_read(OFF_CYC, rd);  chk("t6_cyc", rd, 32'h0);
        wb_read(OFF_CTRL, rd); chk("t6_ctrl", rd, 32'h0000_0002);
        @(negedge clock);
        chk("t6_valid_after", {31'b0, inst_valid}, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
